// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width default, register address width
// and the write-back request layout used by the write-back stage.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

  // Writes to x0 are architecturally dead, so they never count as a request.
  function automatic logic is_live(input logic en, input logic [REG_ADDR_W-1:0] rd);
    return en && (rd != {REG_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency write-back results ({rd, data}) until
// the register-file write port is free.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W + XLEN_DEFAULT,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == {CW{1'b0}});

  // Entry storage; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the main pipe and a long-latency unit onto one
// register-file write port; the pipe always wins, ll results wait in wb_fifo.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int DEPTH     = 4,
  parameter int WATCH_REG = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_regwrite,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_write_data,
  output logic [XLEN-1:0]       watch_data,
  output logic [CW-1:0]         ll_count
);

  localparam int QW = REG_ADDR_W + XLEN;

  logic                  pipe_live;
  logic                  ll_live;
  logic                  q_push;
  logic                  q_pop;
  logic                  q_empty;
  logic [QW-1:0]         q_head;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  // Ready depends only on occupancy so the ll unit sees no path from its own valid.
  assign ll_ready  = (ll_count < CW'(DEPTH));
  assign pipe_live = is_live(pipe_regwrite, pipe_rd);
  assign ll_live   = is_live(ll_valid && ll_ready, ll_rd);

  wb_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({ll_rd, ll_data}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (ll_count),
    .empty     (q_empty)
  );

  // Priority select: live pipe, then queue head, then ll bypass of an empty queue.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = wb_rd;
    sel_data  = wb_write_data;
    q_push    = 1'b0;
    q_pop     = 1'b0;
    if (pipe_live) begin
      sel_valid = 1'b1;
      sel_rd    = pipe_rd;
      sel_data  = pipe_data;
      q_push    = ll_live;
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_rd    = q_head[QW-1 -: REG_ADDR_W];
      sel_data  = q_head[XLEN-1:0];
      q_pop     = 1'b1;
      q_push    = ll_live;
    end else if (ll_live) begin
      sel_valid = 1'b1;
      sel_rd    = ll_rd;
      sel_data  = ll_data;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Registered write port plus watch-register mirror.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_regwrite   <= 1'b0;
      wb_rd         <= {REG_ADDR_W{1'b0}};
      wb_write_data <= {XLEN{1'b0}};
      watch_data    <= {XLEN{1'b0}};
    end else begin
      wb_regwrite <= sel_valid;
      if (sel_valid) begin
        wb_rd         <= sel_rd;
        wb_write_data <= sel_data;
      end
      if (sel_valid && (sel_rd == REG_ADDR_W'(WATCH_REG))) begin
        watch_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations for pipe, bypass,
// conflict/drain, full+pop, x0 handling and asynchronous reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_write_data;
  logic [31:0] watch_data;
  logic [2:0]  ll_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .DEPTH(4), .WATCH_REG(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_regwrite (pipe_regwrite),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .ll_valid      (ll_valid),
    .ll_ready      (ll_ready),
    .ll_rd         (ll_rd),
    .ll_data       (ll_data),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_write_data (wb_write_data),
    .watch_data    (watch_data),
    .ll_count      (ll_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_regwrite = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    check("rst_we",    {63'd0, wb_regwrite}, 64'd0);
    check("rst_rd",    {59'd0, wb_rd}, 64'd0);
    check("rst_data",  {32'd0, wb_write_data}, 64'd0);
    check("rst_watch", {32'd0, watch_data}, 64'd0);
    check("rst_cnt",   {61'd0, ll_count}, 64'd0);
    check("rst_rdy",   {63'd0, ll_ready}, 64'd1);
    @(negedge clk); reset = 1'b0;
    tick();

    // Pipe only
    pipe_regwrite = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick(); idle();
    check("pipe_we",    {63'd0, wb_regwrite}, 64'd1);
    check("pipe_rd",    {59'd0, wb_rd}, 64'd5);
    check("pipe_data",  {32'd0, wb_write_data}, 64'hDEADBEEF);
    check("pipe_watch", {32'd0, watch_data}, 64'd0);
    tick();
    check("idle_we",    {63'd0, wb_regwrite}, 64'd0);
    check("idle_rd",    {59'd0, wb_rd}, 64'd5);
    check("idle_data",  {32'd0, wb_write_data}, 64'hDEADBEEF);

    // Bypass into empty queue
    ll_valid = 1'b1; ll_rd = 5'd1; ll_data = 32'h1234;
    check("byp_rdy", {63'd0, ll_ready}, 64'd1);
    tick(); idle();
    check("byp_we",    {63'd0, wb_regwrite}, 64'd1);
    check("byp_rd",    {59'd0, wb_rd}, 64'd1);
    check("byp_data",  {32'd0, wb_write_data}, 64'h1234);
    check("byp_watch", {32'd0, watch_data}, 64'h1234);
    check("byp_cnt",   {61'd0, ll_count}, 64'd0);

    // Conflict: pipe rd=3 for 6 cycles, ll pushes rd=10..13
    for (int i = 0; i < 6; i++) begin
      pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h300 + i;
      ll_valid = (i < 4); ll_rd = 5'(10 + i); ll_data = 32'hA0 + i;
      tick();
      check("cf_rd",   {59'd0, wb_rd}, 64'd3);
      check("cf_data", {32'd0, wb_write_data}, 64'h300 + i);
      check("cf_cnt",  {61'd0, ll_count}, (i < 4) ? 64'(i + 1) : 64'd4);
    end
    check("cf_rdy_full", {63'd0, ll_ready}, 64'd0);
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("dr_we",   {63'd0, wb_regwrite}, 64'd1);
      check("dr_rd",   {59'd0, wb_rd}, 64'(10 + k));
      check("dr_data", {32'd0, wb_write_data}, 64'hA0 + k);
      check("dr_cnt",  {61'd0, ll_count}, 64'(3 - k));
    end
    check("dr_watch", {32'd0, watch_data}, 64'h1234);
    tick();
    check("dr_end_we", {63'd0, wb_regwrite}, 64'd0);

    // Full + pop: fill with rd=20..23 behind the pipe
    for (int i = 0; i < 4; i++) begin
      pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_data = 32'd0;
      ll_valid = 1'b1; ll_rd = 5'(20 + i); ll_data = 32'h200 + i;
      tick();
    end
    check("fp_cnt4", {61'd0, ll_count}, 64'd4);
    pipe_regwrite = 1'b0; pipe_rd = 5'd0;
    ll_valid = 1'b1; ll_rd = 5'd24; ll_data = 32'h204;
    check("fp_rdy0", {63'd0, ll_ready}, 64'd0);
    tick();
    check("fp_rd20", {59'd0, wb_rd}, 64'd20);
    check("fp_cnt3", {61'd0, ll_count}, 64'd3);
    check("fp_rdy1", {63'd0, ll_ready}, 64'd1);
    tick();
    check("fp_rd21",  {59'd0, wb_rd}, 64'd21);
    check("fp_cnt3b", {61'd0, ll_count}, 64'd3);
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_dr_rd",   {59'd0, wb_rd}, 64'(22 + k));
      check("fp_dr_data", {32'd0, wb_write_data}, 64'h202 + k);
    end
    check("fp_empty", {61'd0, ll_count}, 64'd0);

    // x0 handling
    pipe_regwrite = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    tick();
    check("x0_cnt1", {61'd0, ll_count}, 64'd1);
    ll_valid = 1'b0; pipe_rd = 5'd0; pipe_data = 32'hBAD;
    tick();
    check("x0_we",   {63'd0, wb_regwrite}, 64'd1);
    check("x0_rd7",  {59'd0, wb_rd}, 64'd7);
    check("x0_data", {32'd0, wb_write_data}, 64'h77);
    check("x0_cnt0", {61'd0, ll_count}, 64'd0);
    idle();
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h99;
    tick(); idle();
    check("x0_ll_we",  {63'd0, wb_regwrite}, 64'd0);
    check("x0_ll_cnt", {61'd0, ll_count}, 64'd0);
    check("x0_ll_rd",  {59'd0, wb_rd}, 64'd7);

    // Asynchronous reset with three queued entries
    for (int i = 0; i < 3; i++) begin
      pipe_regwrite = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h500 + i;
      ll_valid = 1'b1; ll_rd = 5'(15 + i); ll_data = 32'h150 + i;
      tick();
    end
    idle();
    check("ar_cnt3", {61'd0, ll_count}, 64'd3);
    #2 reset = 1'b1;
    #1;
    check("ar_we",    {63'd0, wb_regwrite}, 64'd0);
    check("ar_rd",    {59'd0, wb_rd}, 64'd0);
    check("ar_data",  {32'd0, wb_write_data}, 64'd0);
    check("ar_watch", {32'd0, watch_data}, 64'd0);
    check("ar_cnt",   {61'd0, ll_count}, 64'd0);
    check("ar_rdy",   {63'd0, ll_ready}, 64'd1);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar_post_we",  {63'd0, wb_regwrite}, 64'd0);
      check("ar_post_cnt", {61'd0, ll_count}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of the write-back path.
REQ-002 SHALL provide parameter DEPTH, default 4, long-latency result queue entries (power of two, >=2).
REQ-003 SHALL provide parameter WATCH_REG, default 1, architectural register mirrored on watch_data.
REQ-004 SHALL provide: clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL provide: pipe_regwrite  in  1  MEM-stage write request (main pipe).
REQ-007 SHALL provide: pipe_rd  in  5  main-pipe destination register.
REQ-008 SHALL provide: pipe_data  in  XLEN  main-pipe write data.
REQ-009 SHALL provide: ll_valid  in  1  long-latency unit (div/mul) result valid.
REQ-010 SHALL provide: ll_ready  out  1  queue can accept an ll result this cycle.
REQ-011 SHALL provide: ll_rd  in  5  long-latency destination register.
REQ-012 SHALL provide: ll_data  in  XLEN  long-latency result data.
REQ-013 SHALL provide: wb_regwrite  out  1  register-file write enable (registered).
REQ-014 SHALL provide: wb_rd  out  5  register-file write address (registered).
REQ-015 SHALL provide: wb_write_data  out  XLEN  register-file write data (registered).
REQ-016 SHALL provide: watch_data  out  XLEN  last value committed to WATCH_REG.
REQ-017 SHALL provide: ll_count  out  $clog2(DEPTH+1)  current queue occupancy.

Function
REQ-018 Pipe request "live" = pipe_regwrite && pipe_rd!=0; pipe_rd==0 requests SHALL be ignored and SHALL NOT consume the write slot.
REQ-019 ll transfer SHALL occur when ll_valid && ll_ready; ll_ready = (ll_count < DEPTH), combinational from count only, not from ll_valid or pipe inputs.
REQ-020 Transferred ll result with ll_rd==0 SHALL be accepted and discarded (not enqueued, never written).
REQ-021 Per cycle, one write SHALL be registered, priority: (1) live pipe request, (2) queue head, (3) ll transfer bypassing an empty queue.
REQ-022 Live pipe request SHALL appear on wb_* exactly 1 cycle later; pipe is never stalled.
REQ-023 ll transfer with queue empty and no live pipe request SHALL bypass directly to wb_* (1-cycle latency, ll_count unchanged).
REQ-024 Otherwise transferred ll results SHALL be enqueued in arrival order; queue head drains in FIFO order on cycles with no live pipe request.
REQ-025 Simultaneous pop and push SHALL be allowed (count unchanged); push while full is impossible by REQ-019 even if a pop occurs that cycle.
REQ-026 Cycles with no write selected SHALL register wb_regwrite=0; wb_rd and wb_write_data SHALL hold previous values.
REQ-027 Pointers SHALL wrap modulo DEPTH; ll_count SHALL range 0..DEPTH.
REQ-028 watch_data SHALL update on the same edge wb_* registers a write with rd==WATCH_REG, to that write's data; otherwise hold.
REQ-029 WAW ordering between pipe and ll destinations is guaranteed by issue logic; block SHALL NOT reorder or check it.

Reset
REQ-030 While reset is high: wb_regwrite=0, wb_rd=0, wb_write_data=0, watch_data=0, ll_count=0, pointers=0, ll_ready=1.
REQ-031 Reset mid-operation SHALL discard all queued entries; no write from pre-reset state SHALL appear after release.

Structure
REQ-032 XLEN default, REG_ADDR_W=5 and the write-back request struct {rd, data} SHALL live in the shared riscv_pkg package.
REQ-033 Queue SHALL be a sub-module wb_fifo (synchronous, DEPTH-parameterised, count output); arbitration and output registers in wb_arbiter.

Verification
REQ-034 Pipe only: pipe_regwrite=1, rd=5, data=0xDEADBEEF -> next cycle wb_regwrite=1, wb_rd=5, wb_write_data=0xDEADBEEF; watch_data stays 0.
REQ-035 Bypass: queue empty, no pipe, ll_valid rd=1 data=0x1234 -> next cycle wb_rd=1, data=0x1234, watch_data=0x1234, ll_count=0.
REQ-036 Conflict: pipe (rd=3) live for 6 cycles while ll pushes rd=10..13 -> ll_count reaches 4, ll_ready=0; after pipe stops, writes rd=10,11,12,13 in order on 4 consecutive cycles.
REQ-037 Full + pop: queue full, pipe idle, ll_valid high -> ll_ready=0 that cycle, head pops, count 3; next cycle ll_ready=1, push+pop keeps count 3.
REQ-038 x0: pipe rd=0 with queue holding rd=7 -> rd=7 written that cycle; ll rd=0 transfer -> count unchanged, no write.
REQ-039 Reset: assert reset asynchronously with count=3 -> all outputs zero immediately, ll_ready=1; after release no queued write appears.
